// File: rtl/transaccion_multi_pkg.sv
// -----------------------------------------------------------------------------
// transaccion_pkg
// Shared definitions for the multi-transaction cashier block:
//   - tipo_t   : transaction type encodings carried on tipo_trans
//   - estado_t : session FSM states (also exported on the debug port)
//   - sat_mask : helper building an all-ones constant of a given width,
//                used as the saturation ceiling of the balance adder
// No ports (package). Optional feature macro used by the block: LIMITE_RETIRO_EN.
// -----------------------------------------------------------------------------
package transaccion_pkg;

   typedef enum logic [1:0] {
      TIPO_DEPOSITO  = 2'b00,
      TIPO_RETIRO    = 2'b01,
      TIPO_CONSULTA  = 2'b10,
      TIPO_RESERVADO = 2'b11
   } tipo_t;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      ESPERA    = 2'b01,
      EJECUTA   = 2'b10,
      RESULTADO = 2'b11
   } estado_t;

   // Widest balance the helper can describe.
   localparam int SAT_MAX_W = 128;

   // Bits [w-1:0] set, everything above cleared; callers slice the low part.
   function automatic logic [SAT_MAX_W-1:0] sat_mask(input int w);
      sat_mask = '0;
      for (int i = 0; i < SAT_MAX_W; i++) begin
         if (i < w) sat_mask[i] = 1'b1;
      end
   endfunction

endpackage

// File: rtl/transaccion_multi_if.sv
// -----------------------------------------------------------------------------
// transaccion_multi_if
// Bundles the card/PIN front-end request side and the dispenser/account-store
// result side of transaccion_multi.
//   master : drives tarjeta_recibida, tipo_trans, monto_stb, monto,
//            balance_inicial; observes all result signals
//   slave  : the transaction block itself
//
// Handshake: monto_stb is a one-cycle request strobe qualifying tipo_trans and
// monto. It is accepted only while the block waits for a request (ocupado = 0,
// session open); ocupado then stays high until the result cycle, in which the
// result pulses (balance_stb, entregar_dinero, fondos_insuficientes,
// tipo_invalido, limite_excedido) are valid for exactly one cycle. Strobes
// presented at any other time are dropped, never queued.
// -----------------------------------------------------------------------------
interface transaccion_multi_if #(
   parameter int MONTO_W   = 32,
   parameter int BALANCE_W = 64
);
   logic                 tarjeta_recibida;
   logic [1:0]           tipo_trans;
   logic                 monto_stb;
   logic [MONTO_W-1:0]   monto;
   logic [BALANCE_W-1:0] balance_inicial;
   logic [BALANCE_W-1:0] balance_actualizado;
   logic                 balance_stb;
   logic                 entregar_dinero;
   logic                 fondos_insuficientes;
   logic                 tipo_invalido;
   logic                 limite_excedido;
   logic                 ocupado;

   modport master (
      output tarjeta_recibida, tipo_trans, monto_stb, monto, balance_inicial,
      input  balance_actualizado, balance_stb, entregar_dinero,
             fondos_insuficientes, tipo_invalido, limite_excedido, ocupado
   );

   modport slave (
      input  tarjeta_recibida, tipo_trans, monto_stb, monto, balance_inicial,
      output balance_actualizado, balance_stb, entregar_dinero,
             fondos_insuficientes, tipo_invalido, limite_excedido, ocupado
   );
endinterface

// File: rtl/transaccion_multi_alu.sv
// -----------------------------------------------------------------------------
// transaccion_alu
// Purely combinational balance arithmetic for transaccion_multi.
// Ports:
//   balance         in  current session balance
//   monto           in  requested amount (unsigned, zero-extended internally)
//   suma_sat        out balance + monto, saturating at all-ones
//   resta           out balance - monto (only meaningful when !insuficiente)
//   insuficiente    out monto > balance
//   acumulado       in  withdrawals so far this session   (LIMITE_RETIRO_EN)
//   acumulado_nuevo out acumulado + monto                 (LIMITE_RETIRO_EN)
//   limite          out acumulado + monto > LIMITE_RETIRO (LIMITE_RETIRO_EN)
// Optional feature macro: LIMITE_RETIRO_EN.
// -----------------------------------------------------------------------------
module transaccion_alu
   import transaccion_pkg::*;
#(
   parameter int MONTO_W       = 32,
   parameter int BALANCE_W     = 64
`ifdef LIMITE_RETIRO_EN
   ,
   parameter int LIMITE_RETIRO = 1000
`endif
) (
   input  logic [BALANCE_W-1:0] balance,
   input  logic [MONTO_W-1:0]   monto,
`ifdef LIMITE_RETIRO_EN
   input  logic [BALANCE_W-1:0] acumulado,
   output logic [BALANCE_W-1:0] acumulado_nuevo,
   output logic                 limite,
`endif
   output logic [BALANCE_W-1:0] suma_sat,
   output logic [BALANCE_W-1:0] resta,
   output logic                 insuficiente
);

   localparam logic [SAT_MAX_W-1:0] SAT_FULL = sat_mask(BALANCE_W);
   localparam logic [BALANCE_W-1:0] SAT      = SAT_FULL[BALANCE_W-1:0];

   logic [BALANCE_W-1:0] monto_ext;
   logic [BALANCE_W:0]   suma_ext;
`ifdef LIMITE_RETIRO_EN
   // One extra bit so a huge amount cannot wrap past the limit comparison.
   localparam logic [BALANCE_W:0] LIMITE_EXT = (BALANCE_W+1)'(LIMITE_RETIRO);
   logic [BALANCE_W:0]   acum_ext;
`endif

   always_comb begin
      monto_ext    = BALANCE_W'(monto);
      suma_ext     = {1'b0, balance} + {1'b0, monto_ext};
      suma_sat     = suma_ext[BALANCE_W] ? SAT : suma_ext[BALANCE_W-1:0];
      insuficiente = (monto_ext > balance);
      resta        = balance - monto_ext;
`ifdef LIMITE_RETIRO_EN
      acum_ext        = {1'b0, acumulado} + {1'b0, monto_ext};
      limite          = (acum_ext > LIMITE_EXT);
      acumulado_nuevo = acum_ext[BALANCE_W-1:0];
`endif
   end

endmodule

// File: rtl/transaccion_multi.sv
// -----------------------------------------------------------------------------
// transaccion_multi
// Card-session transaction controller: after a card insertion edge it serves
// any number of deposit / withdrawal / balance-query requests until the card
// is removed. Request strobe at cycle N -> registered result pulses at N+2.
// Ports:
//   clk        in  rising-edge clock
//   reset      in  synchronous, active-low
//   bus        slave modport of transaccion_multi_if (request + result signals)
//   estado_dbg out current FSM state, for observation only
// Optional feature macro: LIMITE_RETIRO_EN (per-session withdrawal ceiling).
// -----------------------------------------------------------------------------
module transaccion_multi
   import transaccion_pkg::*;
#(
   parameter int MONTO_W       = 32,
   parameter int BALANCE_W     = 64,
   parameter int LIMITE_RETIRO = 1000
) (
   input  logic                clk,
   input  logic                reset,
   transaccion_multi_if.slave  bus,
   output estado_t             estado_dbg
);

   estado_t              estado_q, estado_d;
   logic                 card_q;
   logic                 armado_q;
   logic [BALANCE_W-1:0] balance_q, balance_d;
   tipo_t                tipo_q, tipo_d;
   logic [MONTO_W-1:0]   monto_q, monto_d;
   logic                 ocupado_q, ocupado_d;
   logic                 bal_stb_q, bal_stb_d;
   logic                 entregar_q, entregar_d;
   logic                 fondos_q, fondos_d;
   logic                 invalido_q, invalido_d;
   logic                 inicio;
   logic [BALANCE_W-1:0] suma_sat, resta;
   logic                 insuficiente;
`ifdef LIMITE_RETIRO_EN
   logic [BALANCE_W-1:0] acum_q, acum_d, acum_nuevo;
   logic                 limite_q, limite_d, limite;
`endif

   // armado_q only rises once the card has been seen low after reset, so a
   // card that is already inserted when reset releases cannot open a session.
   assign inicio = bus.tarjeta_recibida & ~card_q & armado_q;

   transaccion_alu #(
      .MONTO_W       (MONTO_W),
      .BALANCE_W     (BALANCE_W)
`ifdef LIMITE_RETIRO_EN
      ,
      .LIMITE_RETIRO (LIMITE_RETIRO)
`endif
   ) u_alu (
      .balance         (balance_q),
      .monto           (monto_q),
`ifdef LIMITE_RETIRO_EN
      .acumulado       (acum_q),
      .acumulado_nuevo (acum_nuevo),
      .limite          (limite),
`endif
      .suma_sat        (suma_sat),
      .resta           (resta),
      .insuficiente    (insuficiente)
   );

   // State register and all other flops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         estado_q   <= IDLE;
         card_q     <= 1'b0;
         armado_q   <= 1'b0;
         balance_q  <= '0;
         tipo_q     <= TIPO_DEPOSITO;
         monto_q    <= '0;
         ocupado_q  <= 1'b0;
         bal_stb_q  <= 1'b0;
         entregar_q <= 1'b0;
         fondos_q   <= 1'b0;
         invalido_q <= 1'b0;
`ifdef LIMITE_RETIRO_EN
         acum_q     <= '0;
         limite_q   <= 1'b0;
`endif
      end else begin
         estado_q   <= estado_d;
         card_q     <= bus.tarjeta_recibida;
         armado_q   <= armado_q | ~bus.tarjeta_recibida;
         balance_q  <= balance_d;
         tipo_q     <= tipo_d;
         monto_q    <= monto_d;
         ocupado_q  <= ocupado_d;
         bal_stb_q  <= bal_stb_d;
         entregar_q <= entregar_d;
         fondos_q   <= fondos_d;
         invalido_q <= invalido_d;
`ifdef LIMITE_RETIRO_EN
         acum_q     <= acum_d;
         limite_q   <= limite_d;
`endif
      end
   end

   // Next-state logic. Card removal wins over a simultaneous strobe in ESPERA;
   // EJECUTA always proceeds to RESULTADO so an accepted request is answered.
   always_comb begin
      estado_d = estado_q;
      unique case (estado_q)
         IDLE:      if (inicio) estado_d = ESPERA;
         ESPERA: begin
            if (!bus.tarjeta_recibida)  estado_d = IDLE;
            else if (bus.monto_stb)     estado_d = EJECUTA;
         end
         EJECUTA:   estado_d = RESULTADO;
         RESULTADO: estado_d = bus.tarjeta_recibida ? ESPERA : IDLE;
         default:   estado_d = IDLE;
      endcase
   end

   // Output / datapath logic: every output is the registered copy of these.
   always_comb begin
      balance_d  = balance_q;
      tipo_d     = tipo_q;
      monto_d    = monto_q;
      ocupado_d  = 1'b0;
      bal_stb_d  = 1'b0;
      entregar_d = 1'b0;
      fondos_d   = 1'b0;
      invalido_d = 1'b0;
`ifdef LIMITE_RETIRO_EN
      acum_d     = acum_q;
      limite_d   = 1'b0;
`endif
      unique case (estado_q)
         IDLE: begin
            if (inicio) begin
               balance_d = bus.balance_inicial;
`ifdef LIMITE_RETIRO_EN
               acum_d    = '0;
`endif
            end
         end
         ESPERA: begin
            if (bus.tarjeta_recibida && bus.monto_stb) begin
               tipo_d    = tipo_t'(bus.tipo_trans);
               monto_d   = bus.monto;
               ocupado_d = 1'b1;
            end
         end
         EJECUTA: begin
            unique case (tipo_q)
               TIPO_DEPOSITO: begin
                  balance_d = suma_sat;
                  bal_stb_d = 1'b1;
               end
               TIPO_RETIRO: begin
                  bal_stb_d = 1'b1;
`ifdef LIMITE_RETIRO_EN
                  // Session ceiling is checked before available funds.
                  if (limite) begin
                     limite_d = 1'b1;
                  end else
`endif
                  if (insuficiente) begin
                     fondos_d = 1'b1;
                  end else begin
                     balance_d  = resta;
                     entregar_d = 1'b1;
`ifdef LIMITE_RETIRO_EN
                     acum_d     = acum_nuevo;
`endif
                  end
               end
               TIPO_CONSULTA:  bal_stb_d  = 1'b1;
               TIPO_RESERVADO: invalido_d = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign bus.balance_actualizado  = balance_q;
   assign bus.balance_stb          = bal_stb_q;
   assign bus.entregar_dinero      = entregar_q;
   assign bus.fondos_insuficientes = fondos_q;
   assign bus.tipo_invalido        = invalido_q;
   assign bus.ocupado              = ocupado_q;
`ifdef LIMITE_RETIRO_EN
   assign bus.limite_excedido      = limite_q;
`else
   assign bus.limite_excedido      = 1'b0;
`endif
   assign estado_dbg               = estado_q;

endmodule

// File: tb/tb_transaccion_multi.sv
// -----------------------------------------------------------------------------
// tb_transaccion_multi
// Self-checking bench for transaccion_multi. A behavioural account model
// (plain arithmetic on a balance and a withdrawal total) predicts each result;
// directed scenarios cover reset, start, saturation, reserved type, busy,
// card removal, mid-transaction reset and the withdrawal ceiling, followed by
// randomized sessions. Build with +define+LIMITE_RETIRO_EN for the ceiling.
// -----------------------------------------------------------------------------
module tb_transaccion_multi;
   import transaccion_pkg::*;

   localparam int MW = 32;
   localparam int BW = 64;
   localparam int LIMITE = 1000;
`ifdef LIMITE_RETIRO_EN
   localparam bit LIMIT_ON = 1'b1;
`else
   localparam bit LIMIT_ON = 1'b0;
`endif
   localparam logic [BW-1:0] MAXBAL = {BW{1'b1}};

   typedef struct packed {
      logic [BW-1:0] bal;
      logic          stb;
      logic          ent;
      logic          fon;
      logic          inv;
      logic          lim;
   } res_t;

   logic    clk;
   logic    reset;
   estado_t estado_dbg;

   transaccion_multi_if #(.MONTO_W(MW), .BALANCE_W(BW)) bus ();

   transaccion_multi #(.MONTO_W(MW), .BALANCE_W(BW), .LIMITE_RETIRO(LIMITE)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .estado_dbg (estado_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   logic [BW-1:0] m_bal;
   logic [BW:0]   m_acum;
   logic [BW-1:0] exp_q[$];

   task automatic model_apply(input logic [1:0] t, input logic [MW-1:0] m, output res_t e);
      logic [BW:0] s;
      e = '0;
      case (t)
         2'b00: begin
            s = {1'b0, m_bal} + (BW+1)'(m);
            m_bal = (s > {1'b0, MAXBAL}) ? MAXBAL : s[BW-1:0];
            e.stb = 1'b1;
         end
         2'b01: begin
            e.stb = 1'b1;
            if (LIMIT_ON && (m_acum + (BW+1)'(m) > (BW+1)'(LIMITE))) e.lim = 1'b1;
            else if (BW'(m) > m_bal) e.fon = 1'b1;
            else begin
               m_bal  = m_bal - BW'(m);
               m_acum = m_acum + (BW+1)'(m);
               e.ent  = 1'b1;
            end
         end
         2'b10: e.stb = 1'b1;
         default: e.inv = 1'b1;
      endcase
      e.bal = m_bal;
      exp_q.push_back(m_bal);
   endtask

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic any_pulse();
      return bus.balance_stb | bus.entregar_dinero | bus.fondos_insuficientes |
             bus.tipo_invalido | bus.limite_excedido;
   endfunction

   task automatic start_session(input logic [BW-1:0] b);
      bus.tarjeta_recibida = 1'b0;
      step();
      bus.balance_inicial  = b;
      bus.tarjeta_recibida = 1'b1;
      step();
      m_bal  = b;
      m_acum = '0;
   endtask

   // Issues one request from ESPERA and returns the result-cycle outputs,
   // ocupado during EJECUTA, and whether everything else was quiet.
   task automatic run_trans(input logic [1:0] t, input logic [MW-1:0] m,
                            output res_t r, output logic ocup_e, output logic quiet);
      bus.tipo_trans = t;
      bus.monto      = m;
      bus.monto_stb  = 1'b1;
      step();
      bus.monto_stb  = 1'b0;
      ocup_e = bus.ocupado;
      quiet  = ~any_pulse();
      step();
      r = '{bus.balance_actualizado, bus.balance_stb, bus.entregar_dinero,
            bus.fondos_insuficientes, bus.tipo_invalido, bus.limite_excedido};
      quiet &= ~bus.ocupado;
      step();
      quiet &= ~any_pulse() & ~bus.ocupado;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      bus.tarjeta_recibida = 1'b0;
      bus.tipo_trans = 2'b00;
      bus.monto_stb = 1'b0;
      bus.monto = '0;
      bus.balance_inicial = 64'd777;
      repeat (5) step();
      n_checks++;
      if ({bus.balance_actualizado, any_pulse(), bus.ocupado} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got bal=%0d pulse=%b ocup=%b required all 0",
                  bus.balance_actualizado, any_pulse(), bus.ocupado);
      end
      n_checks++;
      if (estado_dbg !== IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got %s required IDLE", estado_dbg.name());
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_start_query();
      res_t r, e;
      logic oe, q;
      start_session(64'd500);
      n_checks++;
      if (bus.balance_actualizado !== 64'd500 || estado_dbg !== ESPERA) begin
         n_fail++;
         $display("FAIL start: got bal=%0d state=%s required 500 ESPERA",
                  bus.balance_actualizado, estado_dbg.name());
      end
      model_apply(2'b10, 32'd0, e);
      run_trans(2'b10, 32'd0, r, oe, q);
      void'(exp_q.pop_front());
      n_checks++;
      if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.bal !== 64'd500 || r.stb !== 1'b1) begin
         n_fail++;
         $display("FAIL query: got bal=%0d flags=%b ocup=%b quiet=%b required bal=500 flags=10000 1 1",
                  r.bal, {r.stb, r.ent, r.fon, r.inv, r.lim}, oe, q);
      end
   endtask

   task automatic test_deposit_withdraw();
      res_t r, e;
      logic oe, q;
      model_apply(2'b00, 32'd250, e);
      run_trans(2'b00, 32'd250, r, oe, q);
      void'(exp_q.pop_front());
      n_checks++;
      if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.bal !== 64'd750) begin
         n_fail++;
         $display("FAIL deposit: got bal=%0d flags=%b required bal=750 flags=%b",
                  r.bal, {r.stb, r.ent, r.fon, r.inv, r.lim}, {e.stb, e.ent, e.fon, e.inv, e.lim});
      end
      model_apply(2'b01, 32'd750, e);
      run_trans(2'b01, 32'd750, r, oe, q);
      void'(exp_q.pop_front());
      n_checks++;
      if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.bal !== 64'd0 || r.ent !== 1'b1) begin
         n_fail++;
         $display("FAIL withdraw_exact: got bal=%0d flags=%b required bal=0 flags=%b",
                  r.bal, {r.stb, r.ent, r.fon, r.inv, r.lim}, {e.stb, e.ent, e.fon, e.inv, e.lim});
      end
   endtask

   task automatic test_insufficient();
      res_t r, e;
      logic oe, q;
      start_session(64'd100);
      model_apply(2'b01, 32'd101, e);
      run_trans(2'b01, 32'd101, r, oe, q);
      void'(exp_q.pop_front());
      n_checks++;
      if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.bal !== 64'd100 || r.fon !== 1'b1 || r.ent !== 1'b0) begin
         n_fail++;
         $display("FAIL insufficient: got bal=%0d flags=%b required bal=100 flags=10100",
                  r.bal, {r.stb, r.ent, r.fon, r.inv, r.lim});
      end
   endtask

   task automatic test_saturation_reserved();
      res_t r, e;
      logic oe, q;
      start_session(MAXBAL - 64'd9);
      model_apply(2'b00, 32'd20, e);
      run_trans(2'b00, 32'd20, r, oe, q);
      void'(exp_q.pop_front());
      n_checks++;
      if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.bal !== MAXBAL) begin
         n_fail++;
         $display("FAIL saturate: got bal=%h required %h", r.bal, MAXBAL);
      end
      model_apply(2'b11, 32'd5, e);
      run_trans(2'b11, 32'd5, r, oe, q);
      void'(exp_q.pop_front());
      n_checks++;
      if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.inv !== 1'b1 || r.stb !== 1'b0) begin
         n_fail++;
         $display("FAIL reserved: got flags=%b required 00010 bal=%h",
                  {r.stb, r.ent, r.fon, r.inv, r.lim}, r.bal);
      end
   endtask

   task automatic test_busy();
      logic seen;
      start_session(64'd1000);
      bus.tipo_trans = 2'b00;
      bus.monto      = 32'd10;
      bus.monto_stb  = 1'b1;
      step();                       // accepted, now EJECUTA
      bus.monto      = 32'd400;     // strobe stays high through EJECUTA and RESULTADO
      step();
      n_checks++;
      if (bus.balance_actualizado !== 64'd1010 || bus.balance_stb !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_first: got bal=%0d stb=%b required 1010 1",
                  bus.balance_actualizado, bus.balance_stb);
      end
      step();
      bus.monto_stb = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         seen |= any_pulse() | bus.ocupado;
         step();
      end
      n_checks++;
      if (seen !== 1'b0 || bus.balance_actualizado !== 64'd1010 || estado_dbg !== ESPERA) begin
         n_fail++;
         $display("FAIL busy_dropped: got activity=%b bal=%0d state=%s required 0 1010 ESPERA",
                  seen, bus.balance_actualizado, estado_dbg.name());
      end
   endtask

   task automatic test_removal();
      logic seen;
      start_session(64'd300);
      bus.tipo_trans = 2'b01;
      bus.monto      = 32'd50;
      bus.monto_stb  = 1'b1;
      step();
      bus.monto_stb  = 1'b0;
      bus.tarjeta_recibida = 1'b0;  // card leaves during EJECUTA
      step();
      n_checks++;
      if (bus.entregar_dinero !== 1'b1 || bus.balance_stb !== 1'b1 || bus.balance_actualizado !== 64'd250) begin
         n_fail++;
         $display("FAIL removal_result: got ent=%b stb=%b bal=%0d required 1 1 250",
                  bus.entregar_dinero, bus.balance_stb, bus.balance_actualizado);
      end
      step();
      n_checks++;
      if (estado_dbg !== IDLE || any_pulse() !== 1'b0) begin
         n_fail++;
         $display("FAIL removal_idle: got state=%s pulse=%b required IDLE 0",
                  estado_dbg.name(), any_pulse());
      end
      bus.monto_stb = 1'b1;         // strobe in IDLE is dropped
      step();
      bus.monto_stb = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         seen |= any_pulse() | bus.ocupado;
         step();
      end
      n_checks++;
      if (seen !== 1'b0 || bus.balance_actualizado !== 64'd250 || estado_dbg !== IDLE) begin
         n_fail++;
         $display("FAIL idle_strobe: got activity=%b bal=%0d state=%s required 0 250 IDLE",
                  seen, bus.balance_actualizado, estado_dbg.name());
      end
   endtask

   task automatic test_reset_mid();
      start_session(64'd300);
      bus.tipo_trans = 2'b00;
      bus.monto      = 32'd5;
      bus.monto_stb  = 1'b1;
      step();
      bus.monto_stb  = 1'b0;
      reset = 1'b0;                 // asserted while EJECUTA
      step();
      n_checks++;
      if ({bus.balance_actualizado, any_pulse(), bus.ocupado} !== '0 || estado_dbg !== IDLE) begin
         n_fail++;
         $display("FAIL reset_mid: got bal=%0d pulse=%b ocup=%b state=%s required 0 0 0 IDLE",
                  bus.balance_actualizado, any_pulse(), bus.ocupado, estado_dbg.name());
      end
      reset = 1'b1;                 // card still inserted at release
      repeat (3) step();
      n_checks++;
      if (estado_dbg !== IDLE) begin
         n_fail++;
         $display("FAIL card_at_release: got %s required IDLE", estado_dbg.name());
      end
      bus.balance_inicial = 64'd42;
      bus.tarjeta_recibida = 1'b0;
      step();
      bus.tarjeta_recibida = 1'b1;
      step();
      n_checks++;
      if (estado_dbg !== ESPERA || bus.balance_actualizado !== 64'd42) begin
         n_fail++;
         $display("FAIL restart: got state=%s bal=%0d required ESPERA 42",
                  estado_dbg.name(), bus.balance_actualizado);
      end
   endtask

   task automatic test_limit();
      res_t r, e;
      logic oe, q;
      start_session(64'd5000);
      model_apply(2'b01, 32'd600, e);
      run_trans(2'b01, 32'd600, r, oe, q);
      void'(exp_q.pop_front());
      n_checks++;
      if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.bal !== 64'd4400) begin
         n_fail++;
         $display("FAIL limit_first: got bal=%0d flags=%b required 4400 11000",
                  r.bal, {r.stb, r.ent, r.fon, r.inv, r.lim});
      end
      model_apply(2'b01, 32'd500, e);
      run_trans(2'b01, 32'd500, r, oe, q);
      void'(exp_q.pop_front());
      n_checks++;
`ifdef LIMITE_RETIRO_EN
      if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.bal !== 64'd4400 || r.lim !== 1'b1 || r.ent !== 1'b0) begin
         n_fail++;
         $display("FAIL limit_hit: got bal=%0d flags=%b required 4400 10001",
                  r.bal, {r.stb, r.ent, r.fon, r.inv, r.lim});
      end
`else
      if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.bal !== 64'd3900 || r.lim !== 1'b0) begin
         n_fail++;
         $display("FAIL no_limit: got bal=%0d flags=%b required 3900 11000",
                  r.bal, {r.stb, r.ent, r.fon, r.inv, r.lim});
      end
`endif
      start_session(64'd5000);
      model_apply(2'b01, 32'd500, e);
      run_trans(2'b01, 32'd500, r, oe, q);
      void'(exp_q.pop_front());
      n_checks++;
      if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.bal !== 64'd4500 || r.ent !== 1'b1) begin
         n_fail++;
         $display("FAIL limit_new_session: got bal=%0d flags=%b required 4500 11000",
                  r.bal, {r.stb, r.ent, r.fon, r.inv, r.lim});
      end
   endtask

   task automatic test_random();
      res_t r, e;
      logic oe, q;
      logic [1:0] t;
      logic [MW-1:0] m;
      logic [BW-1:0] b;
      logic [BW-1:0] exp_bal;
      for (int s = 0; s < 8; s++) begin
         if ($urandom_range(0, 3) == 0) b = MAXBAL - BW'($urandom_range(0, 3000));
         else                           b = BW'($urandom_range(0, 3000));
         start_session(b);
         for (int k = 0; k < 10; k++) begin
            t = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) m = MW'($urandom());
            else                           m = MW'($urandom_range(0, 1200));
            model_apply(t, m, e);
            run_trans(t, m, r, oe, q);
            exp_bal = exp_q.pop_front();
            n_checks++;
            if ({r, oe, q} !== {e, 1'b1, 1'b1} || r.bal !== exp_bal) begin
               n_fail++;
               $display("FAIL rnd[%0d.%0d] t=%0d m=%0d: got bal=%0d flags=%b ocup=%b quiet=%b required bal=%0d flags=%b",
                        s, k, t, m, r.bal, {r.stb, r.ent, r.fon, r.inv, r.lim}, oe, q,
                        exp_bal, {e.stb, e.ent, e.fon, e.inv, e.lim});
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      m_bal  = '0;
      m_acum = '0;
      test_reset();
      test_start_query();
      test_deposit_withdraw();
      test_insufficient();
      test_saturation_reserved();
      test_busy();
      test_removal();
      test_reset_mid();
      test_limit();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
